dac_sample_sequencer: RTL and testbench

//  Buffers DAC codes written by RV_CPU and replays them at a programmable sample rate to NUM_CH DAC channels, round-robin.

---
 rtl/dac_seq_pkg.sv | 21 ++
 rtl/dac_sample_sequencer_if.sv | 13 +
 rtl/dac_sample_sequencer_fifo.sv | 68 ++++++
 rtl/dac_sample_sequencer.sv | 170 +++++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC sample sequencer: FSM state encoding,
// default geometry and the priming threshold helper.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } seq_state_t;

  localparam int DEF_WIDTH  = 10;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DIV_W  = 8;

  // Samples required before replay may start: one per channel, capped by FIFO size.
  function automatic int prime_level(input int num_ch, input int depth);
    return (num_ch < depth) ? num_ch : depth;
  endfunction

endpackage

// File: rtl/dac_sample_sequencer_if.sv
// CPU-to-sequencer sample handshake (valid/data/ready).
interface dac_sample_sequencer_if #(
  parameter int WIDTH = 10
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/dac_sample_sequencer_fifo.sv
// seq_fifo: DEPTH x WIDTH sample buffer with occupancy count; full/empty are
// derived from the count so the pointers may wrap naturally.
module seq_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign level   = level_reg;

  // Head entry is presented combinationally; the consumer registers it.
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Replays buffered CPU DAC codes round-robin over NUM_CH channels at a programmable rate.
// Optional SEQ_TEST_RAMP_EN adds a test_ramp input that substitutes a sawtooth for FIFO data.
module dac_sample_sequencer
  import dac_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic                    CLK,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic [DIV_W-1:0]        rate_div,
`ifdef SEQ_TEST_RAMP_EN
  input  logic                    test_ramp,
`endif
  dac_sample_sequencer_if.slave   cpu,
  output logic [NUM_CH*WIDTH-1:0] dac_code,
  output logic [NUM_CH-1:0]       dac_upd,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int LW        = $clog2(DEPTH) + 1;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRIME_LVL = prime_level(NUM_CH, DEPTH);

  seq_state_t       state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_lim_reg;
  logic [CH_W-1:0]  ch_ptr_reg;
  logic             underflow_reg;
  logic             tick;
  logic             run_tick;
  logic             ramp_sel;
  logic             load;
  logic             pop;
  logic [WIDTH-1:0] load_code;
  logic [WIDTH-1:0] fifo_rd_data;
  logic [LW-1:0]    fifo_level;
  logic             fifo_full;
  logic             fifo_empty;

  seq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (cpu.in_valid),
    .pop     (pop),
    .wr_data (cpu.in_data),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cpu.in_ready = !fifo_full;
  assign level        = fifo_level;
  assign underflow    = underflow_reg;

  // The limit is latched only at wrap so a mid-count rate_div change cannot skip a tick.
  assign tick     = (state_reg != IDLE) && (div_cnt_reg == div_lim_reg);
  assign run_tick = (state_reg == RUN) && en && tick && !clear;
  assign load     = run_tick && (ramp_sel || !fifo_empty);
  assign pop      = run_tick && !ramp_sel && !fifo_empty;

`ifdef SEQ_TEST_RAMP_EN
  logic [WIDTH-1:0] ramp_reg;

  assign ramp_sel  = test_ramp;
  assign load_code = ramp_sel ? ramp_reg : fifo_rd_data;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ramp_reg <= '0;
    end else if (clear) begin
      ramp_reg <= '0;
    end else if (load && ramp_sel) begin
      ramp_reg <= ramp_reg + WIDTH'(1);
    end
  end
`else
  assign ramp_sel  = 1'b0;
  assign load_code = fifo_rd_data;
`endif

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      div_lim_reg <= '0;
    end else if (clear || (state_reg == IDLE) || tick) begin
      div_cnt_reg <= '0;
      div_lim_reg <= rate_div;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = en ? PRIME : IDLE;
    end else if (!en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = PRIME;
        PRIME:   if (fifo_level >= LW'(PRIME_LVL)) state_next = RUN;
        RUN:     state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ch_ptr_reg    <= '0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      ch_ptr_reg    <= '0;
      underflow_reg <= 1'b0;
    end else begin
      if (load) begin
        ch_ptr_reg <= (ch_ptr_reg == CH_W'(NUM_CH - 1)) ? '0 : ch_ptr_reg + CH_W'(1);
      end
      if (run_tick && !ramp_sel && fifo_empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WIDTH-1:0] code_reg;
      logic             upd_reg;
      logic             hit;

      assign hit = load && (ch_ptr_reg == CH_W'(gi));

      always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
          code_reg <= '0;
          upd_reg  <= 1'b0;
        end else begin
          upd_reg <= hit;
          if (hit) begin
            code_reg <= load_code;
          end
        end
      end

      assign dac_code[gi*WIDTH +: WIDTH] = code_reg;
      assign dac_upd[gi]                 = upd_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Directed bench for dac_sample_sequencer (WIDTH=10, NUM_CH=2, DEPTH=8); the ramp
// scenario is built only when SEQ_TEST_RAMP_EN is defined.
module tb_dac_sample_sequencer;
  import dac_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        clear;
  logic [7:0]  rate_div;
  logic        test_ramp;
  logic [19:0] dac_code;
  logic [1:0]  dac_upd;
  logic        underflow;
  logic [3:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  int         n_ev;
  int         ev_cyc  [0:2047];
  logic [1:0] ev_upd  [0:2047];
  logic [9:0] ev_code [0:2047];
  int         lvl_min;
  int         lvl_max;

  dac_sample_sequencer_if #(.WIDTH(10)) cpu_if ();

  dac_sample_sequencer #(
    .WIDTH  (10),
    .NUM_CH (2),
    .DEPTH  (8),
    .DIV_W  (8)
  ) dut (
    .CLK       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .clear     (clear),
    .rate_div  (rate_div),
`ifdef SEQ_TEST_RAMP_EN
    .test_ramp (test_ramp),
`endif
    .cpu       (cpu_if),
    .dac_code  (dac_code),
    .dac_upd   (dac_upd),
    .underflow (underflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  // Record every dac_upd pulse over a fixed window, plus level extremes.
  task automatic watch(input int cycles);
    n_ev    = 0;
    lvl_min = 99;
    lvl_max = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (int'(level) < lvl_min) lvl_min = int'(level);
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (dac_upd != 2'b00 && n_ev < 2048) begin
        ev_cyc[n_ev]  = i;
        ev_upd[n_ev]  = dac_upd;
        ev_code[n_ev] = dac_upd[1] ? dac_code[19:10] : dac_code[9:0];
        n_ev++;
      end
    end
  endtask

  initial begin
    reset_n          = 1'b0;
    en               = 1'b0;
    clear            = 1'b0;
    rate_div         = 8'd0;
    test_ramp        = 1'b0;
    cpu_if.in_valid  = 1'b0;
    cpu_if.in_data   = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_dac_code", 32'(dac_code), 32'h0);
    check("rst_dac_upd", 32'(dac_upd), 32'h0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(cpu_if.in_ready), 32'd1);
    check("rst_underflow", 32'(underflow), 32'd0);

    // Priming and paced replay at rate_div=3
    rate_div = 8'd3; en = 1'b1;
    cpu_if.in_valid = 1'b1; cpu_if.in_data = 10'h100;
    @(negedge clk);
    check("prime_state1", 32'(dut.state_reg), 32'(PRIME));
    check("prime_level1", 32'(level), 32'd1);
    cpu_if.in_data = 10'h200;
    @(negedge clk);
    check("prime_state2", 32'(dut.state_reg), 32'(PRIME));
    check("prime_level2", 32'(level), 32'd2);
    cpu_if.in_data = 10'h3FF;
    @(negedge clk);
    cpu_if.in_valid = 1'b0;
    watch(30);
    check("rate_n_ev", 32'(n_ev), 32'd3);
    check("rate_upd0", 32'(ev_upd[0]), 32'd1);
    check("rate_code0", 32'(ev_code[0]), 32'h100);
    check("rate_upd1", 32'(ev_upd[1]), 32'd2);
    check("rate_code1", 32'(ev_code[1]), 32'h200);
    check("rate_upd2", 32'(ev_upd[2]), 32'd1);
    check("rate_code2", 32'(ev_code[2]), 32'h3FF);
    check("rate_gap01", 32'(ev_cyc[1] - ev_cyc[0]), 32'd4);
    check("rate_gap12", 32'(ev_cyc[2] - ev_cyc[1]), 32'd4);
    check("rate_underflow", 32'(underflow), 32'd1);

    en = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_idle_underflow", 32'(underflow), 32'd0);
    check("clr_idle_dac_code", 32'(dac_code), 32'({10'h200, 10'h3FF}));
    check("clr_idle_state", 32'(dut.state_reg), 32'(IDLE));

    // Fill to full while disabled; the ninth sample must be refused
    for (int i = 0; i < 8; i++) begin
      cpu_if.in_valid = 1'b1; cpu_if.in_data = 10'(32'h10 + i);
      @(negedge clk);
    end
    check("full_level", 32'(level), 32'd8);
    check("full_in_ready", 32'(cpu_if.in_ready), 32'd0);
    cpu_if.in_data = 10'h0AA;
    @(negedge clk);
    check("full_level_9th", 32'(level), 32'd8);
    cpu_if.in_valid = 1'b0;

    // Drain at one sample per cycle, then underflow with codes held
    rate_div = 8'd0; en = 1'b1;
    watch(20);
    check("drain_n_ev", 32'(n_ev), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_upd%0d", k), 32'(ev_upd[k]), (k % 2 == 1) ? 32'd2 : 32'd1);
      check($sformatf("drain_code%0d", k), 32'(ev_code[k]), 32'h10 + 32'(k));
      if (k > 0) check($sformatf("drain_gap%0d", k), 32'(ev_cyc[k] - ev_cyc[k-1]), 32'd1);
    end
    check("drain_underflow", 32'(underflow), 32'd1);
    check("drain_level", 32'(level), 32'd0);
    check("drain_dac_hold", 32'(dac_code), 32'({10'h017, 10'h016}));

    // One pop to move ch_ptr to 1, then slow the rate and build level=5 in RUN
    cpu_if.in_valid = 1'b1; cpu_if.in_data = 10'h155;
    @(negedge clk);
    cpu_if.in_valid = 1'b0; rate_div = 8'd200;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cpu_if.in_valid = 1'b1; cpu_if.in_data = 10'(32'h20 + i);
      @(negedge clk);
    end
    cpu_if.in_valid = 1'b0;
    check("pre_clr_level", 32'(level), 32'd5);
    check("pre_clr_state", 32'(dut.state_reg), 32'(RUN));
    check("pre_clr_ch_ptr", 32'(dut.ch_ptr_reg), 32'd1);
    check("pre_clr_ch0", 32'(dac_code[9:0]), 32'h155);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_level", 32'(level), 32'd0);
    check("clr_underflow", 32'(underflow), 32'd0);
    check("clr_ch_ptr", 32'(dut.ch_ptr_reg), 32'd0);
    check("clr_state", 32'(dut.state_reg), 32'(PRIME));
    check("clr_dac_code", 32'(dac_code), 32'({10'h017, 10'h155}));

    // Asynchronous reset in the middle of a cycle with data buffered
    for (int i = 0; i < 3; i++) begin
      cpu_if.in_valid = 1'b1; cpu_if.in_data = 10'(32'h30 + i);
      @(negedge clk);
    end
    cpu_if.in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_dac_code", 32'(dac_code), 32'h0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_in_ready", 32'(cpu_if.in_ready), 32'd1);
    check("arst_underflow", 32'(underflow), 32'd0);
    check("arst_state", 32'(dut.state_reg), 32'(IDLE));
    @(negedge clk);
    en = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

`ifdef SEQ_TEST_RAMP_EN
    begin
      int bad;
      rate_div = 8'd0; en = 1'b1; test_ramp = 1'b1;
      cpu_if.in_valid = 1'b1; cpu_if.in_data = 10'h001;
      @(negedge clk);
      cpu_if.in_data = 10'h002;
      @(negedge clk);
      cpu_if.in_valid = 1'b0;
      watch(1040);
      check("ramp_enough_ev", 32'(n_ev >= 1025), 32'd1);
      check("ramp_code0", 32'(ev_code[0]), 32'h0);
      check("ramp_upd0", 32'(ev_upd[0]), 32'd1);
      check("ramp_code1", 32'(ev_code[1]), 32'h1);
      check("ramp_upd1", 32'(ev_upd[1]), 32'd2);
      check("ramp_code2", 32'(ev_code[2]), 32'h2);
      check("ramp_code1023", 32'(ev_code[1023]), 32'h3FF);
      check("ramp_code1024", 32'(ev_code[1024]), 32'h0);
      bad = 0;
      for (int k = 0; k < n_ev; k++) begin
        if (ev_code[k] !== 10'(k % 1024)) bad++;
        if (ev_upd[k] !== ((k % 2 == 1) ? 2'b10 : 2'b01)) bad++;
      end
      check("ramp_seq_bad", 32'(bad), 32'd0);
      check("ramp_level_min", 32'(lvl_min), 32'd2);
      check("ramp_level_max", 32'(lvl_max), 32'd2);
      check("ramp_underflow", 32'(underflow), 32'd0);
      test_ramp = 1'b0; en = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
